// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler: round-robin shared bit-serial adder for two requesters
module serial_add_scheduler #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             owner,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic             carry, last_owner, accept, winner, s, carry_next, last_bit;
   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end
   // next state, arbitration, serial adder bit and status outputs
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done0      = 1'b0;
      done1      = 1'b0;
      busy       = state != IDLE;
      winner     = (req0 && req1) ? ~last_owner : req1;
      s          = a_sr[0] ^ b_sr[0] ^ carry;
      carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      last_bit   = count == CW'(1);
      case (state)
         IDLE: begin
            accept     = req0 || req1;
            state_next = accept ? RUN : IDLE;
         end
         RUN:  state_next = last_bit ? DONE : RUN;
         DONE: begin
            done0      = ~owner;
            done1      = owner;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
   // operand load on accept, one serial add step per RUN cycle, result capture on the final step
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_sr       <= '0;
         b_sr       <= '0;
         sum_sr     <= '0;
         sum        <= '0;
         carry      <= 1'b0;
         cout       <= 1'b0;
         count      <= '0;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
      end else begin
         gnt0 <= accept && !winner;
         gnt1 <= accept && winner;
         if (accept) begin
            a_sr       <= winner ? a1 : a0;
            b_sr       <= winner ? b1 : b0;
            carry      <= 1'b0;
            count      <= CW'(WIDTH);
            owner      <= winner;
            last_owner <= winner;
         end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {s, sum_sr[WIDTH-1:1]};
            carry  <= carry_next;
            count  <= count - CW'(1);
            if (last_bit) begin
               sum  <= {s, sum_sr[WIDTH-1:1]};
               cout <= carry_next;
            end
         end
      end
   end
endmodule

// File: doc/serial_add_scheduler.md
SERIAL_ADD_SCHEDULER -- requirements
Module: serial_add_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand/sum width and the number of serial bit cycles (minimum 2).
REQ-002 The block SHALL have input clock, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit, asynchronous, active-high.
REQ-004 The block SHALL have inputs req0 and req1, 1 bit each, add requests from requester 0 and requester 1.
REQ-005 The block SHALL have inputs a0 and b0, WIDTH bits each, operands of requester 0.
REQ-006 The block SHALL have inputs a1 and b1, WIDTH bits each, operands of requester 1.
REQ-007 The block SHALL have outputs gnt0 and gnt1, 1 bit each, one-cycle accept pulses.
REQ-008 The block SHALL have outputs done0 and done1, 1 bit each, one-cycle result-valid pulses.
REQ-009 The block SHALL have output sum, WIDTH bits, the last result, LSB-first serial accumulation.
REQ-010 The block SHALL have output cout, 1 bit, the carry out of the last result.
REQ-011 The block SHALL have output owner, 1 bit, the index of the requester whose operation is in progress or was last completed.
REQ-012 The block SHALL have output busy, 1 bit, high in the RUN and DONE states.

Function
REQ-013 The block SHALL contain a single shared bit-serial full adder (one sum bit and one carry register), operand shift registers A and B, a sum shift register, a down-counter and a 3-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, at an edge where req0 or req1 is high, the block SHALL grant one requester. The chosen operands load into A and B, carry is cleared to 0, the counter loads WIDTH, owner is set to the winner, and the FSM moves to RUN.
REQ-015 Arbitration SHALL be round-robin: when only one request is high, that requester wins. When both are high, the requester that is not the last_owner wins. last_owner resets to 1, so requester 0 wins the first tie.
REQ-016 gntN SHALL be registered and high only during the single cycle that follows the accept edge.
REQ-017 At each edge in RUN, the block SHALL compute s = A[0]^B[0]^carry and carry_next = majority(A[0], B[0], carry), shift s into the sum register MSB (shifting right), shift A and B right, update carry, and decrement the counter.
REQ-018 At the RUN edge where the counter equals 1, the FSM SHALL move to DONE, sum SHALL then hold (a+b) mod 2^WIDTH, and cout SHALL hold the final carry.
REQ-019 doneN (N = owner) SHALL be high during the DONE cycle only. DONE SHALL return to IDLE at the next edge.
REQ-020 The latency from the accept edge to the doneN pulse SHALL be exactly WIDTH+1 cycles, and the back-to-back issue period SHALL be WIDTH+2 cycles.
REQ-021 req0 and req1 SHALL be ignored in RUN and DONE. A requester SHALL hold req until it sees gnt. Deasserting req before grant SHALL have no effect.
REQ-022 Operand inputs SHALL be sampled only at the accept edge; later changes to them SHALL not affect the result.
REQ-023 sum, cout and owner SHALL hold their values after DONE until the next DONE. Intermediate bits in the sum register SHALL not be relied upon before DONE.
REQ-024 The block SHALL never assert gnt0 and gnt1 in the same cycle, nor done0 and done1 in the same cycle.

Reset
REQ-025 On reset assertion, the block SHALL immediately force: FSM to IDLE, counter to 0, carry to 0, A, B and sum to 0, cout to 0, owner to 0, last_owner to 1, and gnt0, gnt1, done0, done1 and busy to 0.
REQ-026 A reset asserted mid-RUN SHALL abort the operation with no done pulse. The first edge after reset release SHALL be able to accept a new request.

Verification
REQ-027 req0 with a0=8'h0F, b0=8'h01 -> gnt0 pulse in the cycle after accept, done0 exactly 9 cycles after the accept edge, sum=8'h10, cout=0, owner=0.
REQ-028 req1 with a1=8'hFF, b1=8'h01 -> done1 pulse, sum=8'h00, cout=1, owner=1. A second run with a1=8'hAA, b1=8'h55 -> sum=8'hFF, cout=0.
REQ-029 After reset, req0 and req1 high together and held -> grants alternate 0,1,0,1 at a 10-cycle period, and results match each requester's operands.
REQ-030 Reset asserted 4 cycles into RUN -> all outputs 0 at once, no done pulse, and a following req0 with 8'h03+8'h04 -> sum=8'h07.
REQ-031 Operands changed and req toggled during RUN -> result unchanged, no extra gnt pulse, and the next grant occurs only after DONE.
